a2d_intf: RTL and testbench
===========================

Name: a2d_intf

Overview:
- SPI master and channel sequencer between the Segway digital core and the ADC128S 12-bit A2D (left load cell, right load cell, battery).
- Each `nxt` pulse performs one two-transaction conversion on the next channel in round-robin order.
- The result is held in a per-channel output register used by the rider-detect, steer-enable and battery/piezo logic.

Parameters:
- LFT_CH, 3'd0, A2D channel of left load cell
- RGHT_CH, 3'd4, A2D channel of right load cell
- BATT_CH, 3'd5, A2D channel of battery voltage

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- nxt  in  1  single-cycle request to start the next conversion
- lft_ld  out  12  latest left load-cell result
- rght_ld  out  12  latest right load-cell result
- batt  out  12  latest battery result
- busy  out  1  high from accepted nxt until result is stored
- A2D_SS_n  out  1  SPI slave select, active low
- A2D_SCLK  out  1  SPI clock, idles high
- A2D_MOSI  out  1  SPI data to A2D
- A2D_MISO  in  1  SPI data from A2D

Behaviour:
- Reset (async, rst_n low) forces:
  - lft_ld, rght_ld, batt = 12'h000; busy = 0.
  - A2D_SS_n = 1, A2D_SCLK = 1, A2D_MOSI = 0.
  - Channel pointer = left; FSM = IDLE.
  - Reset mid-transaction aborts immediately; no partial result is written.
- Round-robin order: left -> right -> batt -> left. The pointer advances only when a result is stored.
- FSM states: IDLE, CMD, GAP, READ, STORE.
  - IDLE: nxt=1 -> CMD, busy=1. nxt is ignored in every other state.
  - CMD: one 16-bit SPI transaction. MOSI word = {2'b00, ch[2:0], 11'h000}; MISO data is discarded. At end of transaction -> GAP.
  - GAP: SS_n held high exactly 1 clk -> READ.
  - READ: one 16-bit SPI transaction. MOSI word is again the command word; captured MISO word goes to STORE.
  - STORE: one clk. Captured word bits [11:0] are written to the register of the current channel; other registers are unchanged. Pointer advances, busy=0, -> IDLE.
  - nxt arriving in the STORE cycle is ignored. nxt arriving in the IDLE cycle that follows is accepted.
- SPI transaction timing (5-bit divider, SCLK = div[4]):
  - At SS_n fall, div is loaded with 5'b10111 (SCLK high, 8-clk front porch). div increments every clk while SS_n is low.
  - MOSI is shifted MSB-first on each SCLK falling edge (div 11111->00000). Bit 15 is presented from SS_n fall.
  - MISO is sampled into the shift register on each SCLK rising edge (div 01111->10000).
  - After the 16th rising edge, when div next reaches 11111, SS_n rises instead of SCLK falling. SCLK stays high with no 17th fall.
  - SS_n low duration per transaction: 520 clks (+/-1). SCLK period 32 clks, 50% duty.
- Conversion latency from nxt to register update: 1043 clks (+/-4). The bench accepts 1030-1060.
- Output registers change only in STORE. They are stable and glitch-free at all other times.

Test Plan:
- Reset check: hold rst_n low with A2D set to nonzero values -> all results 0, SS_n=1, SCLK=1, busy=0. Assert rst_n low mid-CMD -> SS_n high in the same cycle.
- Single conversion: lft_cell_set=12'h3A5, pulse nxt -> two transactions, both MOSI words 16'h0000. lft_ld=12'h3A5 within 1060 clks; rght_ld and batt remain 0. SCLK period 32 and exactly 16 rising edges per transaction.
- Round robin: rght_cell_set=12'h7C0, batt_set=12'hD2F, three nxt pulses spaced 1100 clks:
  - second pulse -> MOSI 16'h2000, rght_ld=12'h7C0;
  - third pulse -> MOSI 16'h2800, batt=12'hD2F;
  - fourth pulse -> channel 0 again.
- nxt while busy: pulse nxt at +100 and +600 clks after the first pulse -> exactly one conversion, busy a single contiguous high window, pointer advanced once.
- Back-to-back: nxt pulsed the cycle busy falls -> accepted. A 1-clk GAP with SS_n high is observed between CMD and READ of each conversion.
- Reset recovery: after a reset mid-READ, pulse nxt -> conversion targets the left channel; previously stored values are reset to 0 and not restored.

Source files
------------

// File: rtl/a2d_intf_if.sv
`default_nettype none
//==============================================================================
// Module : a2d_intf_if
// Desc   : Conversion request/result bundle and ADC128S SPI pins for a2d_intf.
// Rev    : 1.0
//==============================================================================
interface a2d_intf_if;
    logic        nxt;
    logic        busy;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        A2D_SS_n;
    logic        A2D_SCLK;
    logic        A2D_MOSI;
    logic        A2D_MISO;

    modport master (
        input  nxt, A2D_MISO,
        output busy, lft_ld, rght_ld, batt, A2D_SS_n, A2D_SCLK, A2D_MOSI
    );

    modport slave (
        output nxt, A2D_MISO,
        input  busy, lft_ld, rght_ld, batt, A2D_SS_n, A2D_SCLK, A2D_MOSI
    );
endinterface
`default_nettype wire

// File: rtl/a2d_intf.sv
`default_nettype none
//==============================================================================
// Module : a2d_intf
// Desc   : ADC128S SPI master with round-robin left/right/battery sequencing.
// Rev    : 1.0
//==============================================================================
module a2d_intf #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    a2d_intf_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        GAP   = 3'd2,
        READ  = 3'd3,
        STORE = 3'd4
    } state_t;

    // Divider preload gives SCLK high with an 8-clk front porch
    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] DIV_RISE = 5'b01111;
    localparam logic [4:0] DIV_FALL = 5'b11111;
    localparam logic [4:0] NUM_BITS = 5'd16;

    state_t      state_q,   state_d;
    logic [1:0]  ptr_q,     ptr_d;
    logic [4:0]  div_q,     div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] tx_q,      tx_d;
    logic [11:0] rx_q,      rx_d;
    logic        ss_n_q,    ss_n_d;
    logic        busy_q,    busy_d;
    logic [11:0] lft_q,     lft_d;
    logic [11:0] rght_q,    rght_d;
    logic [11:0] batt_q,    batt_d;

    logic [2:0]  ch_sel;
    logic [15:0] cmd_word;

    always_comb begin
        case (ptr_q)
            2'd1:    ch_sel = RGHT_CH;
            2'd2:    ch_sel = BATT_CH;
            default: ch_sel = LFT_CH;
        endcase
        cmd_word = {2'b00, ch_sel, 11'h000};
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        batt_d    = batt_q;

        case (state_q)
            IDLE: begin
                if (bus.nxt) begin
                    state_d   = CMD;
                    busy_d    = 1'b1;
                    ss_n_d    = 1'b0;
                    div_d     = DIV_LOAD;
                    tx_d      = cmd_word;
                    bit_cnt_d = 5'd0;
                end
            end

            CMD, READ: begin
                // After the 16th rise the would-be falling edge ends the frame instead
                if (div_q == DIV_FALL && bit_cnt_q == NUM_BITS) begin
                    ss_n_d  = 1'b1;
                    div_d   = DIV_LOAD;
                    state_d = (state_q == CMD) ? GAP : STORE;
                end else begin
                    div_d = div_q + 5'd1;
                    if (div_q == DIV_RISE) begin
                        rx_d      = {rx_q[10:0], bus.A2D_MISO};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    if (div_q == DIV_FALL) begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                end
            end

            GAP: begin
                state_d   = READ;
                ss_n_d    = 1'b0;
                div_d     = DIV_LOAD;
                tx_d      = cmd_word;
                bit_cnt_d = 5'd0;
            end

            STORE: begin
                case (ptr_q)
                    2'd0:    lft_d  = rx_q;
                    2'd1:    rght_d = rx_q;
                    default: batt_d = rx_q;
                endcase
                ptr_d   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            div_q     <= DIV_LOAD;
            bit_cnt_q <= 5'd0;
            tx_q      <= 16'h0000;
            rx_q      <= 12'h000;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            lft_q     <= 12'h000;
            rght_q    <= 12'h000;
            batt_q    <= 12'h000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            batt_q    <= batt_d;
        end
    end

    assign bus.A2D_SS_n = ss_n_q;
    assign bus.A2D_SCLK = div_q[4];
    assign bus.A2D_MOSI = tx_q[15];
    assign bus.busy     = busy_q;
    assign bus.lft_ld   = lft_q;
    assign bus.rght_ld  = rght_q;
    assign bus.batt     = batt_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_intf.sv
`default_nettype none
//==============================================================================
// Module : tb_a2d_intf
// Desc   : Directed bench with an ADC128S slave model and conversion model.
// Rev    : 1.0
//==============================================================================
module tb_a2d_intf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a2d_intf_if bus();

    a2d_intf #(
        .LFT_CH  (3'd0),
        .RGHT_CH (3'd4),
        .BATT_CH (3'd5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] lft_set, rght_set, batt_set;
    logic [2:0]  ch_code [3] = '{3'd0, 3'd4, 3'd5};
    logic [15:0] last_word = 16'hFFFF;

    function automatic void chk(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void chk_rng(string name, longint act, longint lo, longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endfunction

    function automatic logic [11:0] chan_val(logic [2:0] code);
        case (code)
            3'd0:    return lft_set;
            3'd4:    return rght_set;
            3'd5:    return batt_set;
            default: return 12'hEEE;
        endcase
    endfunction

    // Conversion model, ADC slave model and per-cycle output comparison
    initial begin : model_and_compare
        logic [11:0] exp_res [3];
        int          exp_ptr, tgt, lat, cyc, last_rise;
        bit          pending;
        logic        prev_ss, prev_sclk, prev_mosi, ss, sclk;
        int          low_cnt, rises, falls, bit_idx, gap_cnt;
        bit          txn_idx;
        logic [15:0] mosi_cap, miso_word, last_cmd;
        exp_res = '{12'h000, 12'h000, 12'h000};
        exp_ptr = 0; tgt = 0; lat = 0; cyc = 0; last_rise = 0; pending = 1'b0;
        prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
        low_cnt = 0; rises = 0; falls = 0; bit_idx = 0; gap_cnt = 0; txn_idx = 1'b0;
        mosi_cap = 16'h0; miso_word = 16'h0; last_cmd = 16'h0;
        bus.A2D_MISO = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_res = '{12'h000, 12'h000, 12'h000};
                exp_ptr = 0; pending = 1'b0; txn_idx = 1'b0; gap_cnt = 0;
                prev_ss = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
                bus.A2D_MISO = 1'b0;
                chk("rst_lft_ld", bus.lft_ld, 12'h000);
                chk("rst_rght_ld", bus.rght_ld, 12'h000);
                chk("rst_batt", bus.batt, 12'h000);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_ss_n", bus.A2D_SS_n, 1'b1);
                chk("rst_sclk", bus.A2D_SCLK, 1'b1);
                chk("rst_mosi", bus.A2D_MOSI, 1'b0);
            end else begin
                cyc++;
                if (pending) begin
                    lat++;
                    if (!bus.busy || lat > 1100) begin
                        chk_rng("conv_latency", lat, 1030, 1060);
                        exp_res[tgt] = chan_val(ch_code[tgt]);
                        exp_ptr = (exp_ptr + 1) % 3;
                        pending = 1'b0;
                    end
                end
                chk("lft_ld", bus.lft_ld, exp_res[0]);
                chk("rght_ld", bus.rght_ld, exp_res[1]);
                chk("batt", bus.batt, exp_res[2]);
                chk("busy", bus.busy, pending);
                if (bus.nxt && !pending) begin
                    pending = 1'b1; lat = 0; tgt = exp_ptr;
                end

                ss   = bus.A2D_SS_n;
                sclk = bus.A2D_SCLK;
                if (prev_ss && !ss) begin
                    if (txn_idx) chk("gap_clks", gap_cnt, 1);
                    chk("sclk_at_ss_fall", sclk, 1'b1);
                    low_cnt = 1; rises = 0; falls = 0; bit_idx = 0; mosi_cap = 16'h0;
                    miso_word = txn_idx ? {4'hA, chan_val(last_cmd[13:11])} : 16'h5F3C;
                    bus.A2D_MISO = 1'b0;
                end else if (!ss) begin
                    low_cnt++;
                    if (prev_sclk && !sclk) begin
                        mosi_cap = {mosi_cap[14:0], prev_mosi};
                        falls++;
                        if (bit_idx < 16) begin
                            bus.A2D_MISO = miso_word[15 - bit_idx];
                            bit_idx++;
                        end
                    end
                    if (!prev_sclk && sclk) begin
                        rises++;
                        if (rises > 1) chk("sclk_period", cyc - last_rise, 32);
                        last_rise = cyc;
                    end
                end else if (!prev_ss && ss) begin
                    chk("rises_per_txn", rises, 16);
                    chk("falls_per_txn", falls, 16);
                    chk_rng("ss_low_clks", low_cnt, 519, 521);
                    chk("txn_only_when_busy", pending, 1'b1);
                    chk("mosi_word", mosi_cap, {2'b00, ch_code[tgt], 11'h000});
                    last_cmd  = mosi_cap;
                    last_word = mosi_cap;
                    bus.A2D_MISO = 1'b0;
                    if (!txn_idx) begin
                        txn_idx = 1'b1; gap_cnt = 1;
                    end else begin
                        txn_idx = 1'b0;
                    end
                end else begin
                    if (txn_idx) gap_cnt++;
                    chk("sclk_idle_high", sclk, 1'b1);
                    chk("mosi_idle_low", bus.A2D_MOSI, 1'b0);
                end
                prev_ss   = ss;
                prev_sclk = sclk;
                prev_mosi = bus.A2D_MOSI;
            end
        end
    end

    task automatic pulse_nxt();
        @(posedge clk); #1 bus.nxt = 1'b1;
        @(posedge clk); #1 bus.nxt = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (k < 1200 && bus.busy) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin : stimulus
        bus.nxt  = 1'b0;
        lft_set  = 12'h3A5;
        rght_set = 12'h7C0;
        batt_set = 12'hD2F;

        repeat (5) @(posedge clk);
        #1;
        chk("reset_lft_lit", bus.lft_ld, 12'h000);
        chk("reset_ss_lit", bus.A2D_SS_n, 1'b1);
        chk("reset_sclk_lit", bus.A2D_SCLK, 1'b1);
        chk("reset_busy_lit", bus.busy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        pulse_nxt(); wait_idle();
        chk("single_lft_lit", bus.lft_ld, 12'h3A5);
        chk("single_rght_lit", bus.rght_ld, 12'h000);
        chk("single_batt_lit", bus.batt, 12'h000);
        chk("single_mosi_lit", last_word, 16'h0000);

        pulse_nxt(); wait_idle();
        chk("rr_rght_lit", bus.rght_ld, 12'h7C0);
        chk("rr_mosi_rght_lit", last_word, 16'h2000);
        pulse_nxt(); wait_idle();
        chk("rr_batt_lit", bus.batt, 12'hD2F);
        chk("rr_mosi_batt_lit", last_word, 16'h2800);
        lft_set = 12'h155;
        pulse_nxt(); wait_idle();
        chk("rr_wrap_lft_lit", bus.lft_ld, 12'h155);
        chk("rr_wrap_mosi_lit", last_word, 16'h0000);

        rght_set = 12'h0F0;
        pulse_nxt();
        repeat (100) @(posedge clk);
        pulse_nxt();
        repeat (500) @(posedge clk);
        pulse_nxt();
        wait_idle();
        chk("busy_ignore_rght_lit", bus.rght_ld, 12'h0F0);
        repeat (200) @(posedge clk);
        #1 chk("busy_ignore_idle_lit", bus.busy, 1'b0);

        batt_set = 12'h123;
        lft_set  = 12'h2E7;
        pulse_nxt(); wait_idle();
        bus.nxt = 1'b1;
        @(posedge clk); #1 bus.nxt = 1'b0;
        chk("b2b_accept_lit", bus.busy, 1'b1);
        wait_idle();
        chk("b2b_batt_lit", bus.batt, 12'h123);
        chk("b2b_lft_lit", bus.lft_ld, 12'h2E7);

        pulse_nxt();
        repeat (200) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midcmd_ss_lit", bus.A2D_SS_n, 1'b1);
        chk("midcmd_sclk_lit", bus.A2D_SCLK, 1'b1);
        chk("midcmd_lft_lit", bus.lft_ld, 12'h000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        lft_set = 12'hABC;
        pulse_nxt(); wait_idle();
        chk("post_rst_lft_lit", bus.lft_ld, 12'hABC);
        pulse_nxt();
        repeat (700) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midread_ss_lit", bus.A2D_SS_n, 1'b1);
        chk("midread_lft_lit", bus.lft_ld, 12'h000);
        chk("midread_busy_lit", bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        lft_set = 12'h64D;
        pulse_nxt(); wait_idle();
        chk("recover_lft_lit", bus.lft_ld, 12'h64D);
        chk("recover_rght_lit", bus.rght_ld, 12'h000);
        chk("recover_batt_lit", bus.batt, 12'h000);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 clks");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
